dog_diff_stream: RTL and testbench
==================================

Name: dog_diff_stream

Overview:
Streaming difference-of-Gaussian (DoG) stage for the SIFT pipeline. It takes one pixel from each of LAYERS Gaussian-blurred streams in lockstep (e.g. the 3x3, 5x5 and 7x7 blur outputs) and emits LAYERS-1 signed differences per pixel. It is a parametrised successor to the single signed-difference unit, adding configurable width and layer count, selectable output modes, saturation, contrast flags, valid/ready flow control and raster-position markers. It feeds the keypoint extrema detector.

Parameters:
PIX_W, 9, unsigned pixel width of each blurred layer.
LAYERS, 4, number of input scale layers (minimum 2).
OUT_W, 10, output difference width: sign-extended if > PIX_W+1, saturated if < PIX_W+1.
COLS, 640, pixels per line.
ROWS, 480, lines per frame.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  input beat present.
in_ready  out  1  block accepts the beat this cycle.
in_data  in  LAYERS*PIX_W  layer k is in bits [k*PIX_W +: PIX_W]; layer 0 is least blurred.
mode  in  2  0 = signed diff, 1 = absolute value, 2 = thresholded signed diff, 3 = reserved (behaves as 0).
thresh  in  PIX_W  contrast threshold (unsigned).
out_valid  out  1  output beat present.
out_ready  in  1  downstream accepts.
out_data  out  (LAYERS-1)*OUT_W  lane k (signed two's complement) in bits [k*OUT_W +: OUT_W].
out_flag  out  LAYERS-1  bit k = 1 when |d_k| >= thresh.
out_sol  out  1  beat is column 0 (start of line).
out_eof  out  1  beat is the last pixel of the frame.

Behaviour:
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- d_k = layer[k+1] - layer[k], computed in DIFF_W = PIX_W+1 signed bits, zero-extending both operands. Range is [-(2^PIX_W-1), 2^PIX_W-1], so no overflow occurs.
- Two-stage pipeline.
  - S1 registers d_k, the |d_k| >= thresh compare, mode, and the position tags.
  - S2 applies the mode and saturation, and drives the outputs.
  - Latency is exactly 2 cycles from input transfer to out_valid with no backpressure.
  - Throughput is 1 beat/cycle.
- Stall rule:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (a combinational path from out_ready is allowed).
  - While stalled, every S2 output holds stable.
- mode and thresh are sampled per beat at input transfer. Changing them mid-stream affects only later beats.
- Mode 1: the lane is |d_k|, which is non-negative.
- Mode 2: the lane is d_k if |d_k| >= thresh, else 0.
- out_flag is computed in every mode. With thresh = 0, all flags are 1.
- Width handling:
  - OUT_W >= DIFF_W: sign-extend.
  - OUT_W < DIFF_W: clamp to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]. Absolute mode clamps to the max positive value.
- Position counters:
  - col (0..COLS-1) and row (0..ROWS-1) advance on input transfer only.
  - col wraps to 0 and increments row. Both wrap to 0 after the last pixel of the frame.
  - out_sol = (col == 0) and out_eof = (col == COLS-1 && row == ROWS-1) for the beat's tags.
- Reset, including mid-frame:
  - s1_valid, s2_valid, col and row go to 0.
  - out_valid = 0, out_data = 0, out_flag = 0, out_sol = 0, out_eof = 0.
  - in_ready = 1 in the first cycle after reset.
  - In-flight beats are discarded. The next accepted beat is position (0,0).
- Simultaneous output and input transfer with the pipeline full: both happen, no bubble and no loss.

Decomposition:
- Package sift_pkg holds:
  - the COLS and ROWS defaults;
  - the mode encoding constants: MODE_DIFF = 0, MODE_ABS = 1, MODE_THR = 2;
  - a width helper function for DIFF_W.
- Sub-module dog_sub_lane holds the per-lane arithmetic:
  - combinational subtract;
  - registered compare;
  - mode, abs and saturate.
- The top generates LAYERS-1 instances of dog_sub_lane and owns the handshake and counters.

Test Plan:
- Basic sign (LAYERS = 2, PIX_W = 9, OUT_W = 10, mode 0):
  - layer0 = 5, layer1 = 6 -> out_data = 10'h001, 2 cycles later.
  - layer0 = 6, layer1 = 5 -> out_data = 10'h3FF (-1).
- Modes (layers {0, 100, 90, 300}, thresh = 20):
  - mode 0 -> lanes {100, -10, 210}, out_flag = 3'b101.
  - mode 1 -> lanes {100, 10, 210}.
  - mode 2 -> lanes {100, 0, 210}.
- Saturation (OUT_W = 8):
  - layers {0, 511} -> 127.
  - layers {511, 0} -> -128.
  - same pair in mode 1 -> 127.
- Backpressure:
  - Random out_ready at 30% duty over 1000 beats -> output sequence matches the model exactly.
  - With out_ready low for 5 cycles, in_ready falls after 2 accepted beats and outputs hold stable.
- Frame markers (COLS = 4, ROWS = 2, continuous stream of 10 beats):
  - out_sol on beats 0, 4 and 8.
  - out_eof only on beat 7.
  - beat 8 is position (0,0) again.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> out_valid = 0 next cycle, the pending beats are never emitted, and the next beat reports out_sol = 1 at (0,0).

Source files
------------

// File: rtl/sift_pkg.sv
// Shared constants and helpers for the SIFT difference-of-Gaussian stage.
package sift_pkg;

    localparam int COLS_DEFAULT = 640;
    localparam int ROWS_DEFAULT = 480;

    typedef enum logic [1:0] {
        MODE_DIFF = 2'd0,
        MODE_ABS  = 2'd1,
        MODE_THR  = 2'd2,
        MODE_RSVD = 2'd3
    } dog_mode_e;

    // One extra bit holds the full signed range of a difference of two unsigned pixels.
    function automatic int diff_w(input int pix_w);
        return pix_w + 1;
    endfunction

endpackage

// File: rtl/dog_diff_stream_if.sv
// Stream bundle for dog_diff_stream: layered pixel input, per-beat config, lane output.
// Handshake: a beat moves on a side exactly when its valid and ready are both high
// at a rising clk edge; a source holds valid and payload stable until that happens.
interface dog_diff_stream_if #(
    parameter int PIX_W  = 9,
    parameter int LAYERS = 4,
    parameter int OUT_W  = 10
);
    logic                            in_valid;
    logic                            in_ready;
    logic [LAYERS*PIX_W-1:0]         in_data;
    logic [1:0]                      mode;
    logic [PIX_W-1:0]                thresh;
    logic                            out_valid;
    logic                            out_ready;
    logic [(LAYERS-1)*OUT_W-1:0]     out_data;
    logic [LAYERS-2:0]               out_flag;
    logic                            out_sol;
    logic                            out_eof;

    modport master (
        output in_valid, in_data, mode, thresh, out_ready,
        input  in_ready, out_valid, out_data, out_flag, out_sol, out_eof
    );

    modport slave (
        input  in_valid, in_data, mode, thresh, out_ready,
        output in_ready, out_valid, out_data, out_flag, out_sol, out_eof
    );
endinterface

// File: rtl/dog_sub_lane.sv
// One DoG lane: hi - lo difference and contrast compare in S1, mode/abs/saturate in S2.
module dog_sub_lane
    import sift_pkg::*;
#(
    parameter int PIX_W = 9,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_load_i,
    input  logic             s2_load_i,
    input  logic [PIX_W-1:0] lo_i,
    input  logic [PIX_W-1:0] hi_i,
    input  logic [PIX_W-1:0] thresh_i,
    input  dog_mode_e        mode_i,
    output logic [OUT_W-1:0] lane_o,
    output logic             flag_o
);
    localparam int DIFF_W = diff_w(PIX_W);

    logic signed [DIFF_W-1:0] diff_c, neg_c, s1_diff_q, mode_val;
    logic [PIX_W-1:0]         mag_c, s1_mag_q;
    logic                     s1_flag_q;
    logic [OUT_W-1:0]         lane_d, lane_q;
    logic                     flag_q;

    assign diff_c = $signed({1'b0, hi_i}) - $signed({1'b0, lo_i});
    assign neg_c  = -diff_c;
    // Magnitude never exceeds 2^PIX_W-1, so PIX_W bits hold it exactly.
    assign mag_c  = diff_c[DIFF_W-1] ? neg_c[PIX_W-1:0] : diff_c[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_diff_q <= '0;
            s1_mag_q  <= '0;
            s1_flag_q <= 1'b0;
        end else if (s1_load_i) begin
            s1_diff_q <= diff_c;
            s1_mag_q  <= mag_c;
            s1_flag_q <= (mag_c >= thresh_i);
        end
    end

    always_comb begin
        mode_val = s1_diff_q;
        case (mode_i)
            MODE_ABS: mode_val = $signed({1'b0, s1_mag_q});
            MODE_THR: mode_val = s1_flag_q ? s1_diff_q : '0;
            default:  mode_val = s1_diff_q;
        endcase
    end

    if (OUT_W >= DIFF_W) begin : g_ext
        assign lane_d = OUT_W'(mode_val);
    end else begin : g_sat
        localparam int MAX_I = 2 ** (OUT_W - 1) - 1;
        localparam int MIN_I = -(2 ** (OUT_W - 1));
        localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'(MAX_I);
        localparam logic signed [DIFF_W-1:0] SAT_MIN = DIFF_W'(MIN_I);
        always_comb begin
            lane_d = mode_val[OUT_W-1:0];
            if (mode_val > SAT_MAX) begin
                lane_d = SAT_MAX[OUT_W-1:0];
            end else if (mode_val < SAT_MIN) begin
                lane_d = SAT_MIN[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            flag_q <= 1'b0;
        end else if (s2_load_i) begin
            lane_q <= lane_d;
            flag_q <= s1_flag_q;
        end
    end

    assign lane_o = lane_q;
    assign flag_o = flag_q;
endmodule

// File: rtl/dog_diff_stream.sv
// Streaming DoG stage: LAYERS blurred pixels in, LAYERS-1 signed differences out,
// two-stage elastic pipeline with raster start-of-line / end-of-frame tags.
module dog_diff_stream
    import sift_pkg::*;
#(
    parameter int PIX_W  = 9,
    parameter int LAYERS = 4,
    parameter int OUT_W  = 10,
    parameter int COLS   = COLS_DEFAULT,
    parameter int ROWS   = ROWS_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    dog_diff_stream_if.slave  bus
);
    localparam int NL    = LAYERS - 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic             s1_valid_q, s2_valid_q;
    logic             s1_adv, s2_adv, in_fire, s2_load;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_col, last_row;
    dog_mode_e        s1_mode_q;
    logic             s1_sol_q, s1_eof_q, s2_sol_q, s2_eof_q;

    // A stage may take new data when it is empty or its content leaves this cycle.
    assign s2_adv      = !s2_valid_q || bus.out_ready;
    assign s1_adv      = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;
    assign in_fire     = bus.in_valid && s1_adv;
    assign s2_load     = s1_valid_q && s2_adv;

    assign last_col = (col_q == COL_W'(COLS - 1));
    assign last_row = (row_q == ROW_W'(ROWS - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_fire) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            s1_mode_q  <= MODE_DIFF;
            s1_sol_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s2_sol_q   <= 1'b0;
            s2_eof_q   <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
            end
            if (in_fire) begin
                s1_mode_q <= dog_mode_e'(bus.mode);
                s1_sol_q  <= (col_q == '0);
                s1_eof_q  <= last_col && last_row;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                s2_sol_q <= s1_sol_q;
                s2_eof_q <= s1_eof_q;
            end
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        dog_sub_lane #(
            .PIX_W (PIX_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .s1_load_i (in_fire),
            .s2_load_i (s2_load),
            .lo_i      (bus.in_data[k*PIX_W +: PIX_W]),
            .hi_i      (bus.in_data[(k+1)*PIX_W +: PIX_W]),
            .thresh_i  (bus.thresh),
            .mode_i    (s1_mode_q),
            .lane_o    (bus.out_data[k*OUT_W +: OUT_W]),
            .flag_o    (bus.out_flag[k])
        );
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_sol   = s2_sol_q;
    assign bus.out_eof   = s2_eof_q;
endmodule

// File: tb/tb_dog_diff_stream.sv
// Bench for dog_diff_stream: a 4-layer/10-bit instance and a 2-layer/8-bit saturating instance.
module tb_dog_diff_stream;
    localparam int EW = 35;
    localparam int TC = 4;
    localparam int TR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dog_diff_stream_if #(.PIX_W(9), .LAYERS(4), .OUT_W(10)) bus_a ();
    dog_diff_stream_if #(.PIX_W(9), .LAYERS(2), .OUT_W(8))  bus_b ();

    dog_diff_stream #(.PIX_W(9), .LAYERS(4), .OUT_W(10), .COLS(TC), .ROWS(TR)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    dog_diff_stream #(.PIX_W(9), .LAYERS(2), .OUT_W(8), .COLS(TC), .ROWS(TR)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_a_q[$];
    logic [EW-1:0] exp_b_q[$];
    int col_m[2];
    int row_m[2];
    logic rand_bp = 1'b0;
    int sol_cnt = 0;
    int eof_cnt = 0;
    logic stall_a = 1'b0, stall_b = 1'b0;
    logic [EW-1:0] prev_a, prev_b, obs_a, obs_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [29:0] od, input logic [2:0] fl,
                                           input logic sol, input logic eof);
        return {eof, sol, fl, od};
    endfunction

    function automatic logic [EW-1:0] model(input logic [35:0] data, input int nl, input int out_w,
                                            input logic [1:0] mode, input logic [8:0] thr,
                                            input logic sol, input logic eof);
        logic [29:0] od, mask, lane;
        logic [2:0]  fl;
        int a, b, d, ad, v, mx, mn;
        od = '0;
        fl = '0;
        mx = (1 << (out_w - 1)) - 1;
        mn = -(1 << (out_w - 1));
        mask = (30'd1 << out_w) - 30'd1;
        for (int k = 0; k < nl - 1; k++) begin
            a = int'(data[k*9 +: 9]);
            b = int'(data[(k+1)*9 +: 9]);
            d = b - a;
            ad = (d < 0) ? -d : d;
            fl[k] = (ad >= int'(thr));
            if (mode == 2'd1) v = ad;
            else if (mode == 2'd2 && !fl[k]) v = 0;
            else v = d;
            if (v > mx) v = mx;
            if (v < mn) v = mn;
            lane = 30'(v) & mask;
            od = od | (lane << (k * out_w));
        end
        return pack(od, fl, sol, eof);
    endfunction

    task automatic accept(input int which, input logic [35:0] data, input logic [1:0] mode,
                          input logic [8:0] thr);
        logic sol, eof;
        sol = (col_m[which] == 0);
        eof = (col_m[which] == TC - 1) && (row_m[which] == TR - 1);
        if (which == 0) exp_a_q.push_back(model(data, 4, 10, mode, thr, sol, eof));
        else            exp_b_q.push_back(model(data, 2, 8, mode, thr, sol, eof));
        if (col_m[which] == TC - 1) begin
            col_m[which] = 0;
            row_m[which] = (row_m[which] == TR - 1) ? 0 : row_m[which] + 1;
        end else begin
            col_m[which]++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int which, input logic [35:0] data, input logic [1:0] mode,
                        input logic [8:0] thr);
        logic acc;
        int waited;
        acc = 1'b0;
        waited = 0;
        if (which == 0) begin
            bus_a.in_valid = 1'b1; bus_a.in_data = data; bus_a.mode = mode; bus_a.thresh = thr;
        end else begin
            bus_b.in_valid = 1'b1; bus_b.in_data = data[17:0]; bus_b.mode = mode; bus_b.thresh = thr;
        end
        while (!acc && waited < 200) begin
            if (rand_bp) bus_a.out_ready = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            acc = (which == 0) ? bus_a.in_ready : bus_b.in_ready;
            if (acc) accept(which, data, mode, thr);
            @(posedge clk);
            #1;
            waited++;
        end
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic drain();
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("drain_a", exp_a_q.size(), 0);
        check("drain_b", exp_b_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_a_q.delete();
        exp_b_q.delete();
        col_m[0] = 0; row_m[0] = 0; col_m[1] = 0; row_m[1] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output side: compare every transferred beat, and require stalled beats to hold.
    always @(negedge clk) begin
        if (rst) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            obs_a = pack(30'(bus_a.out_data), 3'(bus_a.out_flag), bus_a.out_sol, bus_a.out_eof);
            obs_b = pack(30'(bus_b.out_data), 3'(bus_b.out_flag), bus_b.out_sol, bus_b.out_eof);
            if (stall_a) check("a_hold", {bus_a.out_valid, obs_a}, {1'b1, prev_a});
            if (stall_b) check("b_hold", {bus_b.out_valid, obs_b}, {1'b1, prev_b});
            if (bus_a.out_valid && bus_a.out_ready) begin
                check("a_has_exp", exp_a_q.size() != 0, 1);
                if (exp_a_q.size() != 0) check("a_beat", obs_a, exp_a_q.pop_front());
                sol_cnt += int'(bus_a.out_sol);
                eof_cnt += int'(bus_a.out_eof);
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                check("b_has_exp", exp_b_q.size() != 0, 1);
                if (exp_b_q.size() != 0) check("b_beat", obs_b, exp_b_q.pop_front());
            end
            stall_a = bus_a.out_valid && !bus_a.out_ready;
            stall_b = bus_b.out_valid && !bus_b.out_ready;
            prev_a = obs_a;
            prev_b = obs_b;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [35:0] sd;
        logic [35:0] mdat;
        logic rdy;
        int acc;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.mode = '0; bus_a.thresh = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.mode = '0; bus_b.thresh = '0;
        bus_b.out_ready = 1'b1;
        col_m[0] = 0; row_m[0] = 0; col_m[1] = 0; row_m[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_a_outs", {bus_a.out_valid, bus_a.out_data, bus_a.out_flag, bus_a.out_sol, bus_a.out_eof}, 0);
        check("rst_a_in_ready", bus_a.in_ready, 1);
        check("rst_b_outs", {bus_b.out_valid, bus_b.out_data, bus_b.out_flag, bus_b.out_sol, bus_b.out_eof}, 0);
        check("rst_b_in_ready", bus_b.in_ready, 1);
        @(posedge clk);
        #1;

        // Basic sign and two-cycle latency.
        send(0, {9'd0, 9'd0, 9'd6, 9'd5}, 2'd0, 9'd0);
        @(negedge clk);
        check("lat_cycle1_valid", bus_a.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", bus_a.out_valid, 1);
        check("basic_plus_one", bus_a.out_data[9:0], 10'h001);
        @(posedge clk);
        #1;
        send(0, {9'd0, 9'd0, 9'd5, 9'd6}, 2'd0, 9'd0);

        // Mode sweep, including reserved mode 3, then zero threshold.
        mdat = {9'd300, 9'd90, 9'd100, 9'd0};
        for (int m = 0; m < 4; m++) send(0, mdat, 2'(m), 9'd20);
        send(0, {9'd7, 9'd7, 9'd7, 9'd7}, 2'd0, 9'd0);

        // Narrow instance: sign and saturation.
        send(1, {18'd0, 9'd6, 9'd5}, 2'd0, 9'd0);
        send(1, {18'd0, 9'd5, 9'd6}, 2'd0, 9'd0);
        send(1, {18'd0, 9'd511, 9'd0}, 2'd0, 9'd0);
        send(1, {18'd0, 9'd0, 9'd511}, 2'd0, 9'd0);
        send(1, {18'd0, 9'd0, 9'd511}, 2'd1, 9'd0);
        send(1, {18'd0, 9'd5, 9'd6}, 2'd2, 9'd3);
        drain();

        // Held output: only two beats fit before in_ready drops.
        bus_a.out_ready = 1'b0;
        bus_a.mode = 2'd0;
        bus_a.thresh = 9'd0;
        acc = 0;
        rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sd = {9'd0, 9'd0, 9'(50 + acc), 9'd3};
            bus_a.in_valid = 1'b1;
            bus_a.in_data = sd;
            @(negedge clk);
            rdy = bus_a.in_ready;
            if (rdy) begin
                accept(0, sd, 2'd0, 9'd0);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        check("stall_accepted", acc, 2);
        check("stall_in_ready_low", rdy, 0);
        bus_a.in_valid = 1'b0;
        drain();

        // Frame markers over 10 continuous beats.
        do_reset();
        sol_cnt = 0;
        eof_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            r = {$urandom(), $urandom()};
            send(0, r[35:0], 2'd0, 9'($urandom_range(0, 511)));
        end
        drain();
        check("frame_sol_count", sol_cnt, 3);
        check("frame_eof_count", eof_cnt, 1);

        // Random backpressure at 30% out_ready.
        rand_bp = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r = {$urandom(), $urandom()};
            send(0, r[35:0], 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
        end
        rand_bp = 1'b0;
        drain();

        // Reset with both stages full.
        bus_a.out_ready = 1'b0;
        send(0, {9'd1, 9'd2, 9'd3, 9'd4}, 2'd0, 9'd0);
        send(0, {9'd9, 9'd8, 9'd7, 9'd6}, 2'd0, 9'd0);
        do_reset();
        @(negedge clk);
        check("midrst_outs", {bus_a.out_valid, bus_a.out_data, bus_a.out_flag, bus_a.out_sol, bus_a.out_eof}, 0);
        check("midrst_in_ready", bus_a.in_ready, 1);
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b1;
        send(0, {9'd40, 9'd30, 9'd20, 9'd10}, 2'd0, 9'd0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_next_valid", bus_a.out_valid, 1);
        check("midrst_next_sol", bus_a.out_sol, 1);
        @(posedge clk);
        #1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
